// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg_pkg
// Brief    : Shared 7-segment pattern constants (active-low, bit 6 = g ..
//            bit 0 = a) and the decoded-digit record type.
// Revision : 1.0 - initial release
// ============================================================================
package seg_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    // Code F is shown as a blank digit by the encoder.
    localparam logic [6:0] SEG_F     = 7'b1111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef struct packed {
        logic [3:0] code;
        logic       dash;
        logic       illegal;
    } seg_dec_t;

endpackage : seg_pkg
`default_nettype wire

// File: rtl/seg_decode.sv
`default_nettype none
// ============================================================================
// Module   : seg_decode
// Brief    : Combinational inverse of the hex-to-segment encoder.
// Revision : 1.0 - initial release
// ============================================================================
module seg_decode
    import seg_pkg::*;
(
    input  logic [6:0] i_seg,
    output seg_dec_t   o_dec
);

    always_comb begin
        o_dec.code    = 4'hF;
        o_dec.dash    = 1'b0;
        o_dec.illegal = 1'b0;
        case (i_seg)
            SEG_0:     o_dec.code = 4'h0;
            SEG_1:     o_dec.code = 4'h1;
            SEG_2:     o_dec.code = 4'h2;
            SEG_3:     o_dec.code = 4'h3;
            SEG_4:     o_dec.code = 4'h4;
            SEG_5:     o_dec.code = 4'h5;
            SEG_6:     o_dec.code = 4'h6;
            SEG_7:     o_dec.code = 4'h7;
            SEG_8:     o_dec.code = 4'h8;
            SEG_9:     o_dec.code = 4'h9;
            SEG_A:     o_dec.code = 4'hA;
            SEG_B:     o_dec.code = 4'hB;
            SEG_C:     o_dec.code = 4'hC;
            SEG_D:     o_dec.code = 4'hD;
            SEG_E:     o_dec.code = 4'hE;
            SEG_BLANK: o_dec.code = 4'hF;
            SEG_DASH:  o_dec.dash = 1'b1;
            default:   o_dec.illegal = 1'b1;
        endcase
    end

endmodule : seg_decode
`default_nettype wire

// File: rtl/seg_capture.sv
`default_nettype none
// ============================================================================
// Module   : seg_capture
// Brief    : Samples the multiplexed segment/anode lines, decodes each stable
//            digit and commits complete frames for self-check and debug.
// Revision : 1.0 - initial release
// ============================================================================
module seg_capture
    import seg_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int STABLE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            segments,
    input  logic [DIGITS-1:0]     anodes,
    output logic [4*DIGITS-1:0]   value,
    output logic [DIGITS-1:0]     dash,
    output logic [DIGITS-1:0]     illegal,
    output logic                  frame_valid
);

    localparam int              C_CNT_W   = $clog2(STABLE);
    localparam int              C_IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [C_CNT_W-1:0] C_CNT_MAX = C_CNT_W'(STABLE - 1);
    localparam logic [C_CNT_W-1:0] C_CNT_PRE = C_CNT_W'(STABLE - 2);

    logic [6:0]          r_s_seg, r_p_seg;
    logic [DIGITS-1:0]   r_s_an, r_p_an;
    logic [C_CNT_W-1:0]  r_cnt;
    logic [DIGITS-1:0]   r_cap;
    logic [4*DIGITS-1:0] r_sh_value;
    logic [DIGITS-1:0]   r_sh_dash, r_sh_ill;
    logic [4*DIGITS-1:0] r_value;
    logic [DIGITS-1:0]   r_dash, r_ill;
    logic                r_frame_valid;

    logic [DIGITS-1:0]   w_act;
    logic                w_onehot;
    logic [C_IDX_W-1:0]  w_idx;
    logic                w_advance;
    logic                w_capture;
    logic                w_commit;
    seg_dec_t            w_dec;

    seg_decode u_decode (
        .i_seg (r_s_seg),
        .o_dec (w_dec)
    );

    // Exactly one anode low selects a digit; anything else is blanking.
    assign w_act    = ~r_s_an;
    assign w_onehot = (w_act != '0) && ((w_act & (w_act - DIGITS'(1))) == '0);

    always_comb begin
        w_idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_act[i]) begin
                w_idx = C_IDX_W'(i);
            end
        end
    end

    assign w_advance = w_onehot && (r_s_seg == r_p_seg) && (r_s_an == r_p_an);
    // Fires only on the step into saturation, so one capture per dwell.
    assign w_capture = w_advance && (r_cnt == C_CNT_PRE);
    assign w_commit  = &r_cap;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s_seg       <= SEG_BLANK;
            r_p_seg       <= SEG_BLANK;
            r_s_an        <= '1;
            r_p_an        <= '1;
            r_cnt         <= '0;
            r_cap         <= '0;
            r_sh_value    <= '0;
            r_sh_dash     <= '0;
            r_sh_ill      <= '0;
            r_value       <= '0;
            r_dash        <= '0;
            r_ill         <= '0;
            r_frame_valid <= 1'b0;
        end else begin
            r_s_seg <= segments;
            r_s_an  <= anodes;
            r_p_seg <= r_s_seg;
            r_p_an  <= r_s_an;

            if (w_advance) begin
                if (r_cnt != C_CNT_MAX) begin
                    r_cnt <= r_cnt + C_CNT_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end

            if (w_capture) begin
                r_sh_value[w_idx*4 +: 4] <= w_dec.code;
                r_sh_dash[w_idx]         <= w_dec.dash;
                r_sh_ill[w_idx]          <= w_dec.illegal;
            end

            r_frame_valid <= w_commit;

            // Commit reads the shadow before any same-cycle capture lands,
            // and that capture survives the clear of the capture mask.
            if (w_commit) begin
                r_value <= r_sh_value;
                r_dash  <= r_sh_dash;
                r_ill   <= r_sh_ill;
                r_cap   <= w_capture ? w_act : '0;
            end else if (w_capture) begin
                r_cap   <= r_cap | w_act;
            end
        end
    end

    assign value       = r_value;
    assign dash        = r_dash;
    assign illegal     = r_ill;
    assign frame_valid = r_frame_valid;

endmodule : seg_capture
`default_nettype wire

// File: tb/tb_seg_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_capture
// Brief    : Self-checking bench for seg_capture: vector table, corner-case
//            sequences and randomized scans against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_seg_capture;

    localparam int DIGITS = 4;
    localparam int STABLE = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  segments;
    logic [3:0]  anodes;
    logic [15:0] value;
    logic [3:0]  dash;
    logic [3:0]  illegal;
    logic        frame_valid;

    always #5 clk = ~clk;

    seg_capture #(.DIGITS(DIGITS), .STABLE(STABLE)) dut (
        .clk         (clk),
        .rst         (rst),
        .segments    (segments),
        .anodes      (anodes),
        .value       (value),
        .dash        (dash),
        .illegal     (illegal),
        .frame_valid (frame_valid)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [6:0] pat [16];
    localparam logic [6:0] P_DASH  = 7'b0111111;
    localparam logic [6:0] P_BLANK = 7'b1111111;
    localparam logic [6:0] P_BAD   = 7'b1010101;

    // Behavioural model: run length of identical valid samples, frame set.
    logic [15:0] m_value, m_shv;
    logic [3:0]  m_dash, m_ill, m_shd, m_shi, m_cap;
    logic        m_fv, m_pending;
    logic [6:0]  m_last_seg;
    logic [3:0]  m_last_an;
    int          m_run;

    int          fv_seen;
    logic [15:0] fv_value;
    logic [3:0]  fv_dash, fv_ill;

    function automatic void ref_decode(input logic [6:0] s, output logic [3:0] code,
                                       output logic d, output logic il);
        code = 4'hF; d = 1'b0; il = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (s == pat[i]) begin
                code = 4'(i); il = 1'b0;
            end
        end
        if (s == P_DASH) begin
            d = 1'b1; il = 1'b0;
        end
    endfunction

    function automatic void model_edge(input logic [6:0] s, input logic [3:0] a, input logic r);
        logic [3:0] code;
        logic       d, il;
        int         idx;
        if (r) begin
            m_value = '0; m_dash = '0; m_ill = '0; m_fv = 1'b0;
            m_shv = '0; m_shd = '0; m_shi = '0; m_cap = '0; m_pending = 1'b0;
            m_run = 0; m_last_an = '1; m_last_seg = P_BLANK;
            return;
        end
        m_fv = 1'b0;
        if (m_pending) begin
            m_value = m_shv; m_dash = m_shd; m_ill = m_shi;
            m_fv = 1'b1; m_cap = '0; m_pending = 1'b0;
        end
        if (m_run == STABLE) begin
            idx = 0;
            for (int i = 0; i < 4; i++) if (!m_last_an[i]) idx = i;
            ref_decode(m_last_seg, code, d, il);
            m_shv[idx*4 +: 4] = code;
            m_shd[idx] = d;
            m_shi[idx] = il;
            m_cap[idx] = 1'b1;
        end
        if (m_cap == 4'hF) m_pending = 1'b1;
        if ($countones(~a) == 1) begin
            if (a == m_last_an && s == m_last_seg && m_run > 0)
                m_run = (m_run < STABLE + 1) ? m_run + 1 : m_run;
            else
                m_run = 1;
        end else begin
            m_run = 0;
        end
        m_last_seg = s;
        m_last_an  = a;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input logic [6:0] s, input logic [3:0] a, input logic r);
        segments = s;
        anodes   = a;
        rst      = r;
        @(posedge clk);
        model_edge(s, a, r);
        #1;
        cyc++;
        checks++;
        if (value !== m_value || dash !== m_dash || illegal !== m_ill || frame_valid !== m_fv) begin
            failures++;
            $display("FAIL model cyc=%0d value=%h/%h dash=%b/%b illegal=%b/%b fv=%b/%b",
                     cyc, value, m_value, dash, m_dash, illegal, m_ill, frame_valid, m_fv);
        end
        if (frame_valid === 1'b1) begin
            fv_seen++;
            fv_value = value; fv_dash = dash; fv_ill = illegal;
        end
        @(negedge clk);
    endtask

    task automatic dwell(input int d, input logic [6:0] s, input int n);
        logic [3:0] a;
        a = 4'b0001 << d;
        a = ~a;
        repeat (n) tick(s, a, 1'b0);
    endtask

    task automatic blank(input int n);
        repeat (n) tick(P_BLANK, 4'hF, 1'b0);
    endtask

    typedef struct packed {
        logic [63:0]     name;
        logic [3:0][6:0] p;
        logic [15:0]     v;
        logic [3:0]      d;
        logic [3:0]      il;
    } vec_t;

    vec_t vecs [6];

    initial begin
        pat[0]  = 7'b1000000; pat[1]  = 7'b1111001; pat[2]  = 7'b0100100; pat[3]  = 7'b0110000;
        pat[4]  = 7'b0011001; pat[5]  = 7'b0010010; pat[6]  = 7'b0000010; pat[7]  = 7'b1111000;
        pat[8]  = 7'b0000000; pat[9]  = 7'b0010000; pat[10] = 7'b0001000; pat[11] = 7'b0000011;
        pat[12] = 7'b1000110; pat[13] = 7'b0100001; pat[14] = 7'b0000110; pat[15] = 7'b1111111;

        vecs[0] = '{"1234", {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, 16'h1234, 4'b0000, 4'b0000};
        vecs[1] = '{"5-_0", {7'b0010010, 7'b0111111, 7'b1111111, 7'b1000000}, 16'h5FF0, 4'b0100, 4'b0000};
        vecs[2] = '{"9A?E", {7'b0010000, 7'b0001000, 7'b1010101, 7'b0000110}, 16'h9AFE, 4'b0000, 4'b0010};
        vecs[3] = '{"ABCD", {7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001}, 16'hABCD, 4'b0000, 4'b0000};
        vecs[4] = '{"678b", {7'b0000010, 7'b1111000, 7'b0000000, 7'b0000011}, 16'h678B, 4'b0000, 4'b0000};
        vecs[5] = '{"CdE0", {7'b1000110, 7'b0100001, 7'b0000110, 7'b1000000}, 16'hCDE0, 4'b0000, 4'b0000};

        // Reset with random pins, then an idle blanked display.
        repeat (3) tick(7'($urandom), 4'($urandom), 1'b1);
        check("reset_value", 32'(value), 32'h0);
        check("reset_dash", 32'(dash), 32'h0);
        check("reset_illegal", 32'(illegal), 32'h0);
        check("reset_fv", 32'(frame_valid), 32'h0);
        fv_seen = 0;
        repeat (20) tick(7'($urandom), 4'hF, 1'b0);
        check("idle_no_fv", 32'(fv_seen), 32'h0);

        foreach (vecs[k]) begin
            fv_seen = 0;
            for (int d = 3; d >= 0; d--) dwell(d, vecs[k].p[d], 8);
            blank(4);
            check($sformatf("vec_%s_fv_count", vecs[k].name), 32'(fv_seen), 32'h1);
            check($sformatf("vec_%s_value", vecs[k].name), 32'(fv_value), 32'(vecs[k].v));
            check($sformatf("vec_%s_dash", vecs[k].name), 32'(fv_dash), 32'(vecs[k].d));
            check($sformatf("vec_%s_illegal", vecs[k].name), 32'(fv_ill), 32'(vecs[k].il));
        end

        // Two-cycle glitch of 8 inside a steady 7 on digit 0.
        fv_seen = 0;
        dwell(0, pat[7], 6);
        dwell(0, pat[8], 2);
        dwell(0, pat[7], 1);
        dwell(3, pat[1], 8);
        dwell(2, pat[2], 8);
        dwell(1, pat[3], 8);
        blank(4);
        check("glitch_fv_count", 32'(fv_seen), 32'h1);
        check("glitch_value", 32'(fv_value), 32'h1237);

        // No anode or two anodes active must never capture.
        fv_seen = 0;
        dwell(3, pat[10], 8);
        dwell(2, pat[11], 8);
        dwell(1, pat[12], 8);
        repeat (10) tick(pat[5], 4'b0000, 1'b0);
        repeat (6) tick(pat[5], 4'b0101, 1'b0);
        check("bad_anodes_no_fv", 32'(fv_seen), 32'h0);
        dwell(0, pat[9], 8);
        blank(4);
        check("bad_anodes_fv_count", 32'(fv_seen), 32'h1);
        check("bad_anodes_value", 32'(fv_value), 32'hABC9);

        // Reset after a partial frame; the next scan starts on the other digits.
        fv_seen = 0;
        dwell(3, pat[1], 8);
        dwell(2, pat[2], 8);
        tick(pat[2], 4'b1011, 1'b1);
        check("midrst_value", 32'(value), 32'h0);
        check("midrst_fv", 32'(frame_valid), 32'h0);
        dwell(1, pat[12], 8);
        dwell(0, pat[13], 8);
        check("midrst_no_early_fv", 32'(fv_seen), 32'h0);
        dwell(3, pat[10], 8);
        dwell(2, pat[11], 8);
        blank(4);
        check("midrst_fv_count", 32'(fv_seen), 32'h1);
        check("midrst_value_abcd", 32'(fv_value), 32'hABCD);

        // Randomized scans compared against the model every cycle.
        for (int t = 0; t < 400; t++) begin
            int         r, n;
            logic [3:0] a;
            logic [6:0] s;
            r = int'($urandom_range(0, 99));
            n = int'($urandom_range(1, 9));
            if (r < 2) begin
                tick(7'($urandom), 4'($urandom), 1'b1);
            end else begin
                if (r < 12) begin
                    a = 4'($urandom);
                end else begin
                    a = 4'b0001 << $urandom_range(0, 3);
                    a = ~a;
                end
                r = int'($urandom_range(0, 99));
                if (r < 80)      s = pat[$urandom_range(0, 15)];
                else if (r < 88) s = P_DASH;
                else             s = 7'($urandom);
                repeat (n) tick(s, a, 1'b0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_seg_capture
`default_nettype wire
